// File: rtl/sample_i2s_tx.sv
// sample_i2s_tx
//   Mono I2S transmitter for the 8-bit WSG mixer output. Samples are queued
//   in a small FIFO, converted from unsigned offset to 16-bit two's
//   complement, and shifted out MSB first in both the left and right slots
//   of each 32-bit frame.
//
// Ports
//   clk          in   system clock, all logic on its rising edge
//   rst_n        in   asynchronous active-low reset
//   sample_in    in   [7:0] unsigned sample, 0x80 is midscale
//   sample_valid in   sample_in valid this cycle
//   sample_ready out  FIFO can accept a sample (combinational from level)
//   underrun_clr in   clears the sticky underrun flag
//   i2s_bclk     out  serial bit clock, period 2*BCLK_DIV clk
//   i2s_lrclk    out  word select, 0 = left, 1 = right
//   i2s_sdata    out  serial data, MSB first, changes on BCLK falling edges
//   fifo_level   out  [$clog2(FIFO_DEPTH):0] FIFO occupancy
//   underrun     out  sticky, set when a frame starts with the FIFO empty
module sample_i2s_tx #(
    parameter int BCLK_DIV   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    sample_in,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    input  logic                          underrun_clr,
    output logic                          i2s_bclk,
    output logic                          i2s_lrclk,
    output logic                          i2s_sdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [7:0]    DIV_LAST = 8'(BCLK_DIV - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

    logic [7:0]    div_cnt;
    logic [4:0]    bit_cnt;
    logic [4:0]    bit_next;
    logic [15:0]   out_word;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic          bclk_wrap;
    logic          bclk_fall;
    logic          frame_load;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          lrclk_next;
    logic          sdata_next;

    assign sample_ready = (fifo_level != LVL_FULL);
    assign fifo_empty   = (fifo_level == '0);
    assign push         = sample_valid && sample_ready;

    assign bclk_wrap  = (div_cnt == DIV_LAST);
    assign bclk_fall  = bclk_wrap && i2s_bclk;
    assign bit_next   = bit_cnt + 5'd1;

    // The next frame's word is fetched on the last bit of the current frame,
    // so the new MSB appears one BCLK later at n = 0.
    assign frame_load = bclk_fall && (bit_next == 5'd31);
    assign pop        = frame_load && !fifo_empty;

    // Word select leads the slot by one bit: high for n = 15..30.
    assign lrclk_next = (bit_next >= 5'd15) && (bit_next != 5'd31);
    assign sdata_next = out_word[4'd15 - bit_next[3:0]];

    // Bit clock divider
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            i2s_bclk <= 1'b0;
        end else if (bclk_wrap) begin
            div_cnt  <= '0;
            i2s_bclk <= ~i2s_bclk;
        end else begin
            div_cnt  <= div_cnt + 8'd1;
        end
    end

    // Serialiser: bit counter, word select and data all move on BCLK falls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= 5'd31;
            i2s_lrclk <= 1'b0;
            i2s_sdata <= 1'b0;
            out_word  <= 16'h0000;
        end else if (bclk_fall) begin
            bit_cnt   <= bit_next;
            i2s_lrclk <= lrclk_next;
            i2s_sdata <= sdata_next;
            if (pop) begin
                out_word <= {mem[rd_ptr] ^ 8'h80, 8'h00};
            end
        end
    end

    // FIFO storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= sample_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Set wins over clear so an underrun is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun <= 1'b0;
        end else if (frame_load && fifo_empty) begin
            underrun <= 1'b1;
        end else if (underrun_clr) begin
            underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sample_i2s_tx.sv
// tb_sample_i2s_tx
//   Directed bench for sample_i2s_tx with default parameters (BCLK_DIV = 4,
//   FIFO_DEPTH = 4). A monitor rebuilds the left and right words of every
//   frame from the serial stream and tracks the bit position itself.
module tb_sample_i2s_tx;

    logic       clk;
    logic       rst_n;
    logic [7:0] sample_in;
    logic       sample_valid;
    logic       sample_ready;
    logic       underrun_clr;
    logic       i2s_bclk;
    logic       i2s_lrclk;
    logic       i2s_sdata;
    logic [2:0] fifo_level;
    logic       underrun;

    int total = 0;
    int bad   = 0;

    sample_i2s_tx #(.BCLK_DIV(4), .FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .underrun_clr (underrun_clr),
        .i2s_bclk     (i2s_bclk),
        .i2s_lrclk    (i2s_lrclk),
        .i2s_sdata    (i2s_sdata),
        .fifo_level   (fifo_level),
        .underrun     (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor state
    logic [4:0]  n_mon = 5'd31;
    logic        prev_bclk = 1'b0;
    logic        prev_sdata = 1'b0;
    logic        prev_rst = 1'b0;
    logic        have_fall = 1'b0;
    logic [15:0] sh = '0;
    logic [15:0] left_word = '0;
    logic [15:0] right_word = '0;
    int          gap = 0;
    int          fall_cnt = 0;
    int          frame_cnt = 0;
    int          lr_err = 0;
    int          gap_err = 0;
    int          glitch = 0;

    always @(negedge clk) begin : mon
        logic [4:0] nn;
        nn = n_mon + 5'd1;
        prev_bclk  <= i2s_bclk;
        prev_sdata <= i2s_sdata;
        prev_rst   <= rst_n;
        if (!rst_n) begin
            n_mon     <= 5'd31;
            have_fall <= 1'b0;
            gap       <= 0;
        end else begin
            gap <= gap + 1;
            if (prev_rst && prev_bclk && !i2s_bclk) begin
                n_mon     <= nn;
                fall_cnt  <= fall_cnt + 1;
                gap       <= 1;
                have_fall <= 1'b1;
                if (have_fall && gap != 8) gap_err <= gap_err + 1;
                if (i2s_lrclk != (nn >= 5'd15 && nn <= 5'd30)) lr_err <= lr_err + 1;
                sh <= {sh[14:0], i2s_sdata};
                if (nn == 5'd15) left_word <= {sh[14:0], i2s_sdata};
                if (nn == 5'd31) begin
                    right_word <= {sh[14:0], i2s_sdata};
                    frame_cnt  <= frame_cnt + 1;
                end
            end else if (prev_rst && i2s_sdata != prev_sdata) begin
                glitch <= glitch + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_n(input logic [4:0] target);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (n_mon != target && k < 300);
        chk("wait_n", 32'(n_mon), 32'(target));
    endtask

    task automatic wait_frame();
        int start;
        int k;
        start = frame_cnt;
        k = 0;
        do begin
            tick();
            k++;
        end while (frame_cnt == start && k < 400);
        chk("frame_wait", 32'(frame_cnt - start), 32'd1);
    endtask

    // Counts clocks from reset release to the first BCLK falling edge.
    task automatic first_fall(input string tag);
        int start;
        int k;
        start = fall_cnt;
        k = 0;
        do begin
            tick();
            k++;
        end while (fall_cnt == start && k < 50);
        chk({tag, "_clks"}, 32'(k), 32'd8);
        chk({tag, "_n"}, 32'(n_mon), 32'd0);
        chk({tag, "_lr"}, 32'(i2s_lrclk), 32'd0);
        chk({tag, "_sd"}, 32'(i2s_sdata), 32'd0);
    endtask

    // Drives sample_valid exactly on the clock of the frame-boundary pop.
    task automatic push_at_pop(input logic [7:0] v);
        wait_n(5'd30);
        repeat (7) tick();
        sample_valid = 1'b1;
        sample_in    = v;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic push_one(input logic [7:0] v);
        sample_valid = 1'b1;
        sample_in    = v;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic clr_pulse();
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
        tick();
    endtask

    logic [7:0]  fill_vals [5] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
    logic [15:0] later_words [4] = '{16'hA000, 16'hB000, 16'hC000, 16'hE000};

    initial begin
        rst_n        = 1'b0;
        sample_in    = 8'h00;
        sample_valid = 1'b0;
        underrun_clr = 1'b0;
        repeat (3) tick();

        chk("rst_bclk",  32'(i2s_bclk),     32'd0);
        chk("rst_lrclk", 32'(i2s_lrclk),    32'd0);
        chk("rst_sdata", 32'(i2s_sdata),    32'd0);
        chk("rst_level", 32'(fifo_level),   32'd0);
        chk("rst_ur",    32'(underrun),     32'd0);
        chk("rst_ready", 32'(sample_ready), 32'd1);

        rst_n = 1'b1;
        first_fall("first");

        // Two idle frames: underrun appears at the first frame boundary.
        wait_n(5'd30);
        chk("ur_before_n31", 32'(underrun), 32'd0);
        wait_frame();
        chk("ur_at_n31",  32'(underrun),   32'd1);
        chk("f1_left",    32'(left_word),  32'h0000);
        chk("f1_right",   32'(right_word), 32'h0000);
        wait_frame();
        chk("f2_left",    32'(left_word),  32'h0000);
        chk("f2_right",   32'(right_word), 32'h0000);
        clr_pulse();
        chk("ur_cleared", 32'(underrun), 32'd0);

        // Single sample 0xAF -> 0x2F00 in the frame after the next boundary.
        push_one(8'hAF);
        chk("one_level", 32'(fifo_level),   32'd1);
        chk("one_ready", 32'(sample_ready), 32'd1);
        wait_frame();
        chk("f3_level",  32'(fifo_level), 32'd0);
        chk("f3_ur",     32'(underrun),   32'd0);
        chk("f3_left",   32'(left_word),  32'h0000);
        wait_frame();
        chk("f4_left",   32'(left_word),  32'h2F00);
        chk("f4_right",  32'(right_word), 32'h2F00);
        chk("f4_ur",     32'(underrun),   32'd1);

        // Fill with five back-to-back writes; the fifth is dropped.
        clr_pulse();
        for (int i = 0; i < 5; i++) begin
            sample_valid = 1'b1;
            sample_in    = fill_vals[i];
            tick();
        end
        sample_valid = 1'b0;
        chk("fill_level", 32'(fifo_level),   32'd4);
        chk("fill_ready", 32'(sample_ready), 32'd0);
        chk("fill_ur",    32'(underrun),     32'd0);

        // Write at the pop clock while full: the write is refused.
        push_at_pop(8'h99);
        chk("full_pop_level", 32'(fifo_level), 32'd3);
        chk("f5_left",  32'(left_word),  32'h2F00);
        chk("f5_right", 32'(right_word), 32'h2F00);
        chk("f5_ur",    32'(underrun),   32'd0);

        // Write at the pop clock with room: level unchanged.
        push_at_pop(8'h60);
        chk("pushpop_level", 32'(fifo_level), 32'd3);
        chk("f6_left",  32'(left_word),  32'h9000);
        chk("f6_right", 32'(right_word), 32'h9000);

        for (int i = 0; i < 4; i++) begin
            wait_frame();
            chk("later_left",  32'(left_word),  32'(later_words[i]));
            chk("later_right", 32'(right_word), 32'(later_words[i]));
            if (i == 2) begin
                chk("f9_level", 32'(fifo_level), 32'd0);
                chk("f9_ur",    32'(underrun),   32'd0);
            end
        end
        chk("f10_ur", 32'(underrun), 32'd1);

        chk("lrclk_pattern", 32'(lr_err),  32'd0);
        chk("bclk_period",   32'(gap_err), 32'd0);
        chk("sdata_glitch",  32'(glitch),  32'd0);

        // Reset in the middle of a frame with a sample queued.
        push_one(8'h55);
        wait_n(5'd20);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_bclk",  32'(i2s_bclk),     32'd0);
        chk("mid_rst_lrclk", 32'(i2s_lrclk),    32'd0);
        chk("mid_rst_sdata", 32'(i2s_sdata),    32'd0);
        chk("mid_rst_level", 32'(fifo_level),   32'd0);
        chk("mid_rst_ur",    32'(underrun),     32'd0);
        chk("mid_rst_ready", 32'(sample_ready), 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        first_fall("restart");
        wait_frame();
        chk("r1_left",  32'(left_word),  32'h0000);
        chk("r1_right", 32'(right_word), 32'h0000);
        chk("r1_ur",    32'(underrun),   32'd1);
        wait_frame();
        chk("r2_left",  32'(left_word),  32'h0000);
        chk("r2_right", 32'(right_word), 32'h0000);
        chk("end_lrclk_pattern", 32'(lr_err), 32'd0);
        chk("end_sdata_glitch",  32'(glitch), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
